// File: rtl/freq_divider_pkg.sv
`timescale 1ns/1ps
// freq_pkg: shared types and default sizes for the frequency divider and its
// edge synchronizer.
package freq_pkg;

  // Default period-counter width (max measurable period 2^CNT_W-1 clk cycles).
  localparam int CNT_W_DEF   = 8;
  // Default divide-ratio input width; divide ratio is n+1.
  localparam int N_W_DEF     = 4;
  // Flip-flops in the in_freq synchronizer chain.
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    RUN     = 2'd3
  } fd_state_t;

endpackage : freq_pkg

// File: rtl/freq_divider_edge_sync.sv
`timescale 1ns/1ps
// edge_sync: multi-stage synchronizer for an asynchronous level, followed by a
// one-cycle rising-edge pulse in the clk domain.
module edge_sync
  import freq_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input through the chain; remember the last synchronized level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-history registers, cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A rise is a synchronized high whose previous synchronized level was low.
  always_comb begin
    sync_out = sync_q[STAGES-1];
    rise     = sync_q[STAGES-1] & ~prev_q;
  end

endmodule : edge_sync

// File: rtl/freq_divider.sv
`timescale 1ns/1ps
// freq_divider: measures the period of in_freq in clk cycles (k), then
// regenerates div_out at in_freq/(n+1) with a half-period of H clk cycles.
module freq_divider
  import freq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_W   = N_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_freq,
  input  logic             adjust,
  input  logic [N_W-1:0]   n,
  output logic             valid,
  output logic             div_out,
  output logic [CNT_W-1:0] k,
  output logic             ovf
);

  // Product width: a full period times the largest ratio never truncates.
  localparam int               P_W     = CNT_W + N_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [P_W-1:0]   h_q, h_d;
  logic [P_W-1:0]   hcnt_q, hcnt_d;
  logic             valid_q, valid_d;
  logic             div_q, div_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic             in_sync_unused;  // synchronized level itself is not needed here
  logic [P_W-1:0]   prod;
  logic [P_W-1:0]   h_new;

  edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (in_freq),
    .sync_out (in_sync_unused),
    .rise     (rise)
  );

  // Half-period for the period now in cnt_q: max(1, cnt*(n+1) >> 1).
  // n only matters at the completing edge, so H itself is the latched ratio.
  always_comb begin
    prod  = P_W'(cnt_q) * (P_W'(n) + P_W'(1));
    h_new = prod >> 1;
    if (h_new == '0) begin
      h_new = P_W'(1);
    end
  end

  // Next-state and datapath: adjust restarts from any state, then per-state work.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    h_d     = h_q;
    hcnt_d  = hcnt_q;
    valid_d = valid_q;
    div_d   = div_q;
    ovf_d   = ovf_q;

    if (adjust) begin
      // Restart wins over everything, including a same-cycle rise; div_out holds.
      state_d = ARM;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Outputs hold until a new measurement is requested.
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            ovf_d   = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            // Publish the period and start the divided waveform from hcnt=0.
            state_d = RUN;
            k_d     = cnt_q;
            h_d     = h_new;
            hcnt_d  = '0;
            valid_d = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            // Timed out: k keeps its previous published value.
            state_d = IDLE;
            ovf_d   = 1'b1;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (hcnt_q == h_q - P_W'(1)) begin
            div_d  = ~div_q;
            hcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + P_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset returns every output to zero at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      h_q     <= '0;
      hcnt_q  <= '0;
      valid_q <= 1'b0;
      div_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      h_q     <= h_d;
      hcnt_q  <= hcnt_d;
      valid_q <= valid_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
    end
  end

  // Drive outputs straight from registers.
  always_comb begin
    valid   = valid_q;
    div_out = div_q;
    k       = k_q;
    ovf     = ovf_q;
  end

endmodule : freq_divider

// File: tb/tb_freq_divider.sv
`timescale 1ns/1ps
// tb_freq_divider: directed stimulus with a scoreboard of expected output
// events (measurement done, div_out toggle, overflow) checked by a monitor.
module tb_freq_divider;

  localparam int CW = 8;
  localparam int NW = 4;

  typedef enum int {EV_MEAS, EV_TOG, EV_OVF} ev_t;
  typedef struct {
    ev_t kind;
    int  val;   // MEAS/OVF: k; TOG: cycles since previous valid-rise/toggle
    int  lat;   // MEAS: cycles from in_freq rise to valid; -1 = not checked
  } ev_s;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          adjust = 1'b0;
  logic [NW-1:0] n = '0;
  logic          in_freq;
  logic          valid, div_out, ovf;
  logic [CW-1:0] k;

  // Stimulus waveform source
  bit  gen_en = 1'b0;
  bit  rnd_in = 1'b0;
  bit  gen_wave = 1'b0;
  bit  gen_nxt;
  int  per_req = 20;
  int  per_cur = 20;
  int  ph = 0;
  int  last_rise_cyc = -1000;
  int  cyc = 0;

  ev_s sb_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  assign in_freq = gen_en ? gen_wave : rnd_in;

  freq_divider #(.CNT_W(CW), .N_W(NW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_freq (in_freq),
    .adjust  (adjust),
    .n       (n),
    .valid   (valid),
    .div_out (div_out),
    .k       (k),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Square wave of per_cur clk cycles, changing 2 ns after posedge.
  always @(posedge clk) begin
    #2;
    if (per_req != per_cur) begin
      per_cur = per_req;
      ph = 0;
    end
    if (gen_en) begin
      ph = (ph + 1 >= per_cur) ? 0 : ph + 1;
      gen_nxt = (ph < per_cur / 2);
      if (gen_nxt && !gen_wave) last_rise_cyc = cyc;
      gen_wave = gen_nxt;
    end else begin
      gen_wave = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic expect_ev(input ev_t kind, input int val, input int lat);
    ev_s e;
    e.kind = kind;
    e.val  = val;
    e.lat  = lat;
    sb_q.push_back(e);
  endtask

  task automatic check_event(input ev_t kind, input int val, input int lat);
    ev_s e;
    if (sb_q.size() == 0) begin
      if (kind != EV_TOG) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_%s: got val %0d expected no event (cycle %0d)",
                 kind.name(), val, cyc);
      end
    end else begin
      e = sb_q.pop_front();
      chk({"event_kind_", e.kind.name()}, int'(kind), int'(e.kind));
      if (kind == e.kind) begin
        chk({"event_val_", e.kind.name()}, val, e.val);
        if (e.lat >= 0) chk({"event_lat_", e.kind.name()}, lat, e.lat);
      end
    end
  endtask

  // Monitor: turn output changes into events and compare with the scoreboard.
  task automatic monitor();
    bit valid_p = 1'b0;
    bit div_p = 1'b0;
    bit ovf_p = 1'b0;
    int last_evt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (valid && !valid_p) begin
          check_event(EV_MEAS, int'(k), cyc - last_rise_cyc);
          last_evt = cyc;
        end
        if (div_out != div_p) begin
          check_event(EV_TOG, cyc - last_evt, -1);
          last_evt = cyc;
        end
        if (ovf && !ovf_p) check_event(EV_OVF, int'(k), -1);
      end
      valid_p = valid;
      div_p   = div_out;
      ovf_p   = ovf;
    end
  endtask

  task automatic pulse_adjust();
    @(negedge clk);
    adjust = 1'b1;
    @(negedge clk);
    adjust = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(posedge clk);
    chk(name, sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic stimulus();
    int a;
    bit saved;
    // Reset with random inputs, held 50 ps
    #2;
    rst    = 1'b0;
    rnd_in = 1'($urandom);
    adjust = 1'($urandom);
    n      = NW'($urandom);
    #0.04;
    chk("rst_valid", int'(valid), 0);
    chk("rst_div_out", int'(div_out), 0);
    chk("rst_k", int'(k), 0);
    chk("rst_ovf", int'(ovf), 0);
    #0.01;
    adjust = 1'b0;
    rnd_in = 1'b0;
    n      = '0;
    rst    = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_valid", int'(valid), 0);

    // Period 20, n=0
    per_req = 20;
    gen_en  = 1'b1;
    repeat (30) @(negedge clk);
    pulse_adjust();
    expect_ev(EV_MEAS, 20, 3);
    for (int i = 0; i < 3; i++) expect_ev(EV_TOG, 10, -1);
    wait_drain("drain_p20_n0", 200);
    chk("k_p20_n0", int'(k), 20);
    chk("valid_p20_n0", int'(valid), 1);

    // Period 20, n=3 -> H=40; n changed to 7 in RUN must not matter
    n = 4'd3;
    pulse_adjust();
    chk("valid_after_adj", int'(valid), 0);
    expect_ev(EV_MEAS, 20, 3);
    expect_ev(EV_TOG, 40, -1);
    expect_ev(EV_TOG, 40, -1);
    for (int i = 0; i < 100 && !valid; i++) @(negedge clk);
    chk("valid_p20_n3", int'(valid), 1);
    n = 4'd7;
    wait_drain("drain_p20_n3", 300);
    chk("k_p20_n3", int'(k), 20);

    // in_freq stuck low: overflow after the full count, k retained
    gen_en = 1'b0;
    repeat (5) @(negedge clk);
    pulse_adjust();
    expect_ev(EV_OVF, 20, -1);
    repeat (249) @(negedge clk);
    chk("ovf_not_yet", int'(ovf), 0);
    repeat (11) @(negedge clk);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_valid", int'(valid), 0);
    chk("ovf_k_kept", int'(k), 20);
    wait_drain("drain_ovf", 10);

    // Remeasure period 20, n=0; adjust clears ovf
    n      = '0;
    gen_en = 1'b1;
    repeat (30) @(negedge clk);
    pulse_adjust();
    chk("ovf_cleared", int'(ovf), 0);
    expect_ev(EV_MEAS, 20, 3);
    expect_ev(EV_TOG, 10, -1);
    wait_drain("drain_remeas", 200);

    // In RUN change period to 10, then adjust: valid drops, div_out frozen
    per_req = 10;
    repeat (30) @(negedge clk);
    @(negedge clk);
    saved  = div_out;
    adjust = 1'b1;
    @(negedge clk);
    adjust = 1'b0;
    chk("valid_drop", int'(valid), 0);
    chk("div_frozen_0", int'(div_out), int'(saved));
    expect_ev(EV_MEAS, 10, 3);
    expect_ev(EV_TOG, 5, -1);
    expect_ev(EV_TOG, 5, -1);
    repeat (8) @(negedge clk);
    chk("div_frozen_8", int'(div_out), int'(saved));
    wait_drain("drain_p10", 200);
    chk("k_p10", int'(k), 10);

    // Reset in the middle of MEASURE
    pulse_adjust();
    a = cyc;
    for (int i = 0; i < 40 && last_rise_cyc <= a; i++) @(negedge clk);
    chk("rise_seen", int'(last_rise_cyc > a), 1);
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_k", int'(k), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_div_out", int'(div_out), 0);
    chk("midrst_ovf", int'(ovf), 0);
    #1 rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_idle_valid", int'(valid), 0);
    chk("post_rst_idle_k", int'(k), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #1ms;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_freq_divider
